// File: rtl/lsu_mem.sv
// Load/store unit with a private word-organised data memory.
// Loads return after RD_LAT cycles with byte/halfword extraction; stores take one cycle.
module lsu_mem #(
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  MEM_OP,
  input  logic [2:0]  LSU_OPT,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        READ_READY,
  output logic        WRITE_DONE,
  output logic [31:0] LSU_RESULT,
  output logic        MISALIGN,
  output logic        BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WaitLast = 4'(RD_LAT - 1);

  localparam logic [2:0] OptLb  = 3'd0;
  localparam logic [2:0] OptLh  = 3'd1;
  localparam logic [2:0] OptLw  = 3'd2;
  localparam logic [2:0] OptLbu = 3'd3;
  localparam logic [2:0] OptLhu = 3'd4;
  localparam logic [2:0] OptSb  = 3'd5;
  localparam logic [2:0] OptSh  = 3'd6;
  localparam logic [2:0] OptSw  = 3'd7;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, WR} state_t;

  state_t        state_q;
  logic [2:0]    opt_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    cnt_q;
  logic          ready_q, done_q, mis_q, busy_q;
  logic [31:0]   result_q;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic [2:0]    normOpt;
  logic [AW+1:0] rdAddr;
  logic [2:0]    rdOpt;
  logic [31:0]   rdWord, rdShift, loadData;
  logic [15:0]   rdHalf;
  logic          loadMis, inMis, storeMis;
  logic [3:0]    byteEn;
  logic [31:0]   wrData;
  logic          unused_addr_hi;

  function automatic logic misAligned(input logic [2:0] opt, input logic [1:0] a);
    case (opt)
      OptLh, OptLhu, OptSh: return a[0];
      OptLw, OptSw:         return a != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  assign unused_addr_hi = ^ADDR[31:AW+2];
  assign accept = START && !busy_q && (MEM_OP == 2'd1 || MEM_OP == 2'd2);

  // Mismatched op/opcode pairs collapse to a full-word access of the requested direction.
  always_comb begin
    normOpt = LSU_OPT;
    if (MEM_OP == 2'd2 && LSU_OPT >= OptSb)
      normOpt = OptLw;
    else if (MEM_OP == 2'd1 && LSU_OPT <= OptLhu)
      normOpt = OptSw;
  end

  // With RD_LAT=1 the read happens on the accepting edge, so the live inputs are used.
  always_comb begin
    rdAddr   = (state_q == IDLE) ? ADDR[AW+1:0] : addr_q;
    rdOpt    = (state_q == IDLE) ? normOpt : opt_q;
    rdWord   = mem[rdAddr[AW+1:2]];
    rdShift  = rdWord >> {rdAddr[1:0], 3'b000};
    rdHalf   = rdAddr[1] ? rdWord[31:16] : rdWord[15:0];
    loadMis  = misAligned(rdOpt, rdAddr[1:0]);
    case (rdOpt)
      OptLb:   loadData = {{24{rdShift[7]}}, rdShift[7:0]};
      OptLbu:  loadData = {24'h0, rdShift[7:0]};
      OptLh:   loadData = {{16{rdHalf[15]}}, rdHalf};
      OptLhu:  loadData = {16'h0, rdHalf};
      default: loadData = rdWord;
    endcase
    if (loadMis)
      loadData = 32'h0;
  end

  always_comb begin
    inMis    = misAligned(normOpt, ADDR[1:0]);
    storeMis = misAligned(opt_q, addr_q[1:0]);
    case (opt_q)
      OptSb: begin
        byteEn = 4'b0001 << addr_q[1:0];
        wrData = wdata_q << {addr_q[1:0], 3'b000};
      end
      OptSh: begin
        byteEn = addr_q[1] ? 4'b1100 : 4'b0011;
        wrData = wdata_q << {addr_q[1], 4'b0000};
      end
      default: begin
        byteEn = 4'b1111;
        wrData = wdata_q;
      end
    endcase
  end

  // Memory is never reset; a reset in flight during WR simply blocks the write.
  always_ff @(posedge CLK) begin
    if (state_q == WR && !RST && !storeMis) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b])
          mem[addr_q[AW+1:2]][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      opt_q    <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      cnt_q    <= 4'd0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            opt_q   <= normOpt;
            addr_q  <= ADDR[AW+1:0];
            wdata_q <= WDATA;
            if (MEM_OP == 2'd1) begin
              state_q <= WR;
              done_q  <= 1'b1;
              mis_q   <= inMis;
            end else if (RD_LAT == 1) begin
              state_q  <= RD_DONE;
              ready_q  <= 1'b1;
              result_q <= loadData;
              mis_q    <= loadMis;
            end else begin
              state_q <= RD_WAIT;
              cnt_q   <= 4'd1;
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q == WaitLast) begin
            state_q  <= RD_DONE;
            ready_q  <= 1'b1;
            result_q <= loadData;
            mis_q    <= loadMis;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RD_DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        WR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign READ_READY = ready_q;
  assign WRITE_DONE = done_q;
  assign LSU_RESULT = result_q;
  assign MISALIGN   = mis_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: timing, extraction, byte lanes, misalignment, reset and wrap.
module tb_lsu_mem;

  localparam int DEPTH  = 256;
  localparam int RD_LAT = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [1:0]  MEM_OP = 2'd0;
  logic [2:0]  LSU_OPT = 3'd0;
  logic [31:0] ADDR = 32'h0;
  logic [31:0] WDATA = 32'h0;
  logic        READ_READY, WRITE_DONE, MISALIGN, BUSY;
  logic [31:0] LSU_RESULT;

  int errors = 0;
  int checks = 0;

  lsu_mem #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MEM_OP(MEM_OP), .LSU_OPT(LSU_OPT),
    .ADDR(ADDR), .WDATA(WDATA), .READ_READY(READ_READY), .WRITE_DONE(WRITE_DONE),
    .LSU_RESULT(LSU_RESULT), .MISALIGN(MISALIGN), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Called at a negedge; returns at the negedge of cycle 1 with inputs scrambled.
  task automatic issue(input logic [1:0] op, input logic [2:0] opt,
                       input logic [31:0] a, input logic [31:0] d);
    START = 1'b1; MEM_OP = op; LSU_OPT = opt; ADDR = a; WDATA = d;
    @(negedge CLK);
    START = 1'b0; MEM_OP = 2'd0; LSU_OPT = 3'd0; ADDR = 32'h0000_0FF4; WDATA = 32'h5555_5555;
  endtask

  task automatic doLoad(input logic [2:0] opt, input logic [31:0] a,
                        output logic [31:0] res, output logic rr, output logic mis);
    issue(2'd2, opt, a, 32'h0);
    repeat (RD_LAT - 1) @(negedge CLK);
    res = LSU_RESULT; rr = READ_READY; mis = MISALIGN;
    @(negedge CLK);
  endtask

  task automatic doStore(input logic [2:0] opt, input logic [31:0] a, input logic [31:0] d,
                         output logic done, output logic mis);
    issue(2'd1, opt, a, d);
    done = WRITE_DONE; mis = MISALIGN;
    @(negedge CLK);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    checks += 5;
    if (READ_READY !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready got=%b exp=0", READ_READY); end
    if (WRITE_DONE !== 1'b0) begin errors++; $display("[TB] FAIL rst_done got=%b exp=0", WRITE_DONE); end
    if (MISALIGN !== 1'b0) begin errors++; $display("[TB] FAIL rst_mis got=%b exp=0", MISALIGN); end
    if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got=%b exp=0", BUSY); end
    if (LSU_RESULT !== 32'h0) begin errors++; $display("[TB] FAIL rst_result got=%h exp=0", LSU_RESULT); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_store_load_timing;
    issue(2'd1, 3'd7, 32'h10, 32'h8081F2F3);
    checks += 3;
    if (WRITE_DONE !== 1'b1) begin errors++; $display("[TB] FAIL sw_done_c1 got=%b exp=1", WRITE_DONE); end
    if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL sw_busy_c1 got=%b exp=1", BUSY); end
    if (MISALIGN !== 1'b0) begin errors++; $display("[TB] FAIL sw_mis_c1 got=%b exp=0", MISALIGN); end
    @(negedge CLK);
    checks += 2;
    if (WRITE_DONE !== 1'b0) begin errors++; $display("[TB] FAIL sw_done_c2 got=%b exp=0", WRITE_DONE); end
    if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL sw_busy_c2 got=%b exp=0", BUSY); end
    issue(2'd2, 3'd2, 32'h10, 32'h0);
    checks += 2;
    if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL lw_busy_c1 got=%b exp=1", BUSY); end
    if (READ_READY !== 1'b0) begin errors++; $display("[TB] FAIL lw_ready_c1 got=%b exp=0", READ_READY); end
    @(negedge CLK);
    checks += 3;
    if (READ_READY !== 1'b1) begin errors++; $display("[TB] FAIL lw_ready_c2 got=%b exp=1", READ_READY); end
    if (LSU_RESULT !== 32'h8081F2F3) begin errors++; $display("[TB] FAIL lw_data got=%h exp=8081f2f3", LSU_RESULT); end
    if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL lw_busy_c2 got=%b exp=1", BUSY); end
    @(negedge CLK);
    checks += 3;
    if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL lw_busy_c3 got=%b exp=0", BUSY); end
    if (READ_READY !== 1'b1) begin errors++; $display("[TB] FAIL lw_ready_hold got=%b exp=1", READ_READY); end
    if (LSU_RESULT !== 32'h8081F2F3) begin errors++; $display("[TB] FAIL lw_data_hold got=%h exp=8081f2f3", LSU_RESULT); end
  endtask

  task automatic test_extract;
    logic [2:0]  opts [7] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd0, 3'd3, 3'd1};
    logic [31:0] addrs [7] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h11, 32'h10};
    logic [31:0] exps [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8081, 32'h0000F2F3,
                              32'hFFFFFFF3, 32'h000000F2, 32'hFFFFF2F3};
    logic [31:0] res;
    logic rr, mis;
    for (int i = 0; i < 7; i++) begin
      doLoad(opts[i], addrs[i], res, rr, mis);
      checks += 2;
      if (res !== exps[i]) begin errors++; $display("[TB] FAIL extract[%0d] got=%h exp=%h", i, res, exps[i]); end
      if (rr !== 1'b1 || mis !== 1'b0) begin errors++; $display("[TB] FAIL extract_flags[%0d] got rr=%b mis=%b exp rr=1 mis=0", i, rr, mis); end
    end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] res;
    logic rr, mis, done;
    doStore(3'd5, 32'h11, 32'h000000AA, done, mis);
    doLoad(3'd2, 32'h10, res, rr, mis);
    checks++;
    if (res !== 32'h8081AAF3) begin errors++; $display("[TB] FAIL sb_lane got=%h exp=8081aaf3", res); end
    doStore(3'd6, 32'h12, 32'h00007E55, done, mis);
    doLoad(3'd2, 32'h10, res, rr, mis);
    checks++;
    if (res !== 32'h7E55AAF3) begin errors++; $display("[TB] FAIL sh_lane got=%h exp=7e55aaf3", res); end
  endtask

  task automatic test_misalign;
    logic [31:0] res;
    logic rr, mis, done;
    doLoad(3'd2, 32'h12, res, rr, mis);
    checks += 3;
    if (mis !== 1'b1) begin errors++; $display("[TB] FAIL lw_mis_pulse got=%b exp=1", mis); end
    if (rr !== 1'b1) begin errors++; $display("[TB] FAIL lw_mis_ready got=%b exp=1", rr); end
    if (res !== 32'h0) begin errors++; $display("[TB] FAIL lw_mis_data got=%h exp=0", res); end
    checks++;
    if (MISALIGN !== 1'b0) begin errors++; $display("[TB] FAIL mis_one_cycle got=%b exp=0", MISALIGN); end
    doLoad(3'd4, 32'h11, res, rr, mis);
    checks++;
    if (mis !== 1'b1 || res !== 32'h0) begin errors++; $display("[TB] FAIL lhu_mis got mis=%b data=%h exp mis=1 data=0", mis, res); end
    doStore(3'd7, 32'h11, 32'hDEADBEEF, done, mis);
    checks++;
    if (mis !== 1'b1) begin errors++; $display("[TB] FAIL sw_mis_pulse got=%b exp=1", mis); end
    doStore(3'd6, 32'h13, 32'h0000BEEF, done, mis);
    checks++;
    if (mis !== 1'b1) begin errors++; $display("[TB] FAIL sh_mis_pulse got=%b exp=1", mis); end
    doLoad(3'd2, 32'h10, res, rr, mis);
    checks++;
    if (res !== 32'h7E55AAF3) begin errors++; $display("[TB] FAIL mis_mem_intact got=%h exp=7e55aaf3", res); end
  endtask

  task automatic test_opcode_mismatch;
    logic [31:0] res;
    logic rr, mis, done;
    issue(2'd2, 3'd5, 32'h10, 32'h0);
    @(negedge CLK);
    checks++;
    if (LSU_RESULT !== 32'h7E55AAF3) begin errors++; $display("[TB] FAIL load_as_lw got=%h exp=7e55aaf3", LSU_RESULT); end
    @(negedge CLK);
    doStore(3'd0, 32'h20, 32'hCAFEF00D, done, mis);
    doLoad(3'd2, 32'h20, res, rr, mis);
    checks++;
    if (res !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL store_as_sw got=%h exp=cafef00d", res); end
  endtask

  task automatic test_back_to_back_ignore;
    issue(2'd2, 3'd2, 32'h20, 32'h0);
    START = 1'b1; MEM_OP = 2'd2; LSU_OPT = 3'd2; ADDR = 32'h10;
    @(negedge CLK);
    START = 1'b0; MEM_OP = 2'd0;
    checks++;
    if (LSU_RESULT !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL latched_addr got=%h exp=cafef00d", LSU_RESULT); end
    @(negedge CLK);
    checks += 2;
    if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_ignored got=%b exp=0", BUSY); end
    if (READ_READY !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_ignore got=%b exp=1", READ_READY); end
    START = 1'b1; MEM_OP = 2'd3; LSU_OPT = 3'd7; ADDR = 32'h10; WDATA = 32'h0;
    @(negedge CLK);
    START = 1'b0; MEM_OP = 2'd0;
    checks += 3;
    if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL op3_busy got=%b exp=0", BUSY); end
    if (WRITE_DONE !== 1'b0) begin errors++; $display("[TB] FAIL op3_done got=%b exp=0", WRITE_DONE); end
    if (READ_READY !== 1'b1) begin errors++; $display("[TB] FAIL op3_ready got=%b exp=1", READ_READY); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] res;
    logic rr, mis;
    issue(2'd2, 3'd2, 32'h10, 32'h0);
    RST = 1'b1;
    #1;
    checks += 3;
    if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL rd_abort_busy got=%b exp=0", BUSY); end
    if (READ_READY !== 1'b0) begin errors++; $display("[TB] FAIL rd_abort_ready got=%b exp=0", READ_READY); end
    if (LSU_RESULT !== 32'h0) begin errors++; $display("[TB] FAIL rd_abort_result got=%h exp=0", LSU_RESULT); end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (READ_READY !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("[TB] FAIL rd_abort_after got rr=%b busy=%b exp 0 0", READ_READY, BUSY); end
    issue(2'd1, 3'd7, 32'h10, 32'hFFFFFFFF);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    doLoad(3'd2, 32'h10, res, rr, mis);
    checks++;
    if (res !== 32'h7E55AAF3) begin errors++; $display("[TB] FAIL rst_mem_intact got=%h exp=7e55aaf3", res); end
  endtask

  task automatic test_wrap;
    logic [31:0] res;
    logic rr, mis, done;
    doStore(3'd7, 32'h400, 32'h12345678, done, mis);
    checks++;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL wrap_done got=%b exp=1", done); end
    doLoad(3'd2, 32'h0, res, rr, mis);
    checks++;
    if (res !== 32'h12345678) begin errors++; $display("[TB] FAIL wrap_data got=%h exp=12345678", res); end
  endtask

  initial begin
    test_reset();
    test_store_load_timing();
    test_extract();
    test_byte_lanes();
    test_misalign();
    test_opcode_mismatch();
    test_back_to_back_ignore();
    test_reset_abort();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
